// File: rtl/pc_upstream_arbiter.sv
// Round-robin merge of NIN word sources onto the single PC upstream channel.
// Multi-word messages keep the grant until their last word, capped at MAX_BURST words.
module pc_upstream_arbiter #(
   parameter int NIN       = 4,
   parameter int NPCcode   = 8,
   parameter int NPCdata   = 24,
   parameter int NOPcode   = 64,
   parameter int MAX_BURST = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NIN-1:0]                      in_v,
   output logic [NIN-1:0]                      in_a,
   input  logic [NIN*(NPCcode+NPCdata)-1:0]    in_d,
   input  logic [NIN-1:0]                      in_last,
   output logic                                out_v,
   input  logic                                out_a,
   output logic [NPCcode+NPCdata-1:0]          out_d,
   output logic [$clog2(NIN)-1:0]              out_src
);

   // state  | meaning
   // IDLE   | round-robin search from rr_ptr, any valid source may win
   // LOCKED | owner is mid-message; only owner may transfer

   localparam int W  = NPCcode + NPCdata;
   localparam int SW = $clog2(NIN);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [NPCcode-1:0] NOP_C = NPCcode'(NOPcode);
   localparam logic [BW-1:0]      MAX_B = BW'(MAX_BURST);
   localparam logic [BW-1:0]      ONE_B = BW'(1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t          state;
   logic [SW-1:0]   rr_ptr;
   logic [SW-1:0]   owner;
   logic [BW-1:0]   burst_cnt;
   logic            active;

   logic [SW-1:0]   sel;
   logic            found;
   logic [W-1:0]    sel_word;
   logic            sel_nop;
   logic            can_load;
   logic            xfer;
   logic            last_hit;

   function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NIN) s = s - NIN;
      return SW'(s);
   endfunction

   // Walk the search order backwards so the nearest valid source to rr_ptr wins.
   always_comb begin
      sel   = rr_ptr;
      found = 1'b0;
      if (state == S_LOCKED) begin
         sel   = owner;
         found = 1'b1;
      end else begin
         for (int k = NIN - 1; k >= 0; k--) begin
            if (in_v[wrap_add(rr_ptr, k)]) begin
               sel   = wrap_add(rr_ptr, k);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_word = in_d[int'(sel)*W +: W];
      sel_nop  = (sel_word[W-1 -: NPCcode] == NOP_C);
      can_load = !out_v || out_a;
      xfer     = active && found && in_v[sel] && (can_load || sel_nop);
      last_hit = in_last[sel] || (burst_cnt + ONE_B == MAX_B);
      in_a     = '0;
      if (xfer) in_a[sel] = 1'b1;
   end

   // active holds off accepts for the first cycle after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         active    <= 1'b0;
         out_v     <= 1'b0;
         out_d     <= '0;
         out_src   <= '0;
      end else begin
         active <= 1'b1;
         if (out_v && out_a) out_v <= 1'b0;
         if (xfer && !sel_nop) begin
            out_v   <= 1'b1;
            out_d   <= sel_word;
            out_src <= sel;
         end
         if (xfer) begin
            if (last_hit) begin
               state     <= S_IDLE;
               rr_ptr    <= wrap_add(sel, 1);
               burst_cnt <= '0;
            end else begin
               state     <= S_LOCKED;
               owner     <= sel;
               burst_cnt <= burst_cnt + ONE_B;
            end
         end
      end
   end

endmodule
